// File: rtl/cell_command_rx.sv
// cell_command_rx -- receive path of the cellphone link.
// Decodes the 8N1 UART stream on rx and parses 4-byte command frames
// (0xA5, CMD, DATA, CSUM with CSUM = CMD + DATA mod 256). Valid frames
// update the registered rider settings.
//
// Ports:
//   c50m        in   system clock (50 MHz)
//   rst_n       in   asynchronous active-low reset
//   rx          in   asynchronous UART line, idles high
//   heart_cap   out  heart-rate set point in bpm (registered)
//   assist_mode out  motor assist mode 0..3 (registered)
//   cmd_strobe  out  one-cycle pulse when a frame is applied
//   frame_err   out  one-cycle pulse when a frame is rejected/aborted
//   rx_busy     out  high while the frame parser is outside HUNT
module cell_command_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
  parameter int unsigned CAP_DEFAULT  = 200,
  parameter int unsigned CAP_MIN      = 60,
  parameter int unsigned CAP_MAX      = 220
) (
  input  logic       c50m,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] heart_cap,
  output logic [1:0] assist_mode,
  output logic       cmd_strobe,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CLKS);
  localparam logic [7:0]       CAP_RST   = 8'(CAP_DEFAULT);
  localparam logic [7:0]       CAP_LO    = 8'(CAP_MIN);
  localparam logic [7:0]       CAP_HI    = 8'(CAP_MAX);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  // ---------------------------------------------------------------
  // Input synchronizer; rxs_prev_q gives the falling-edge detector.
  // ---------------------------------------------------------------
  logic rx_meta_q, rxs_q, rxs_prev_q;

  always_ff @(posedge c50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // ---------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e        rx_st_q, rx_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sr_q, sr_d;
  logic [7:0]       byte_q, byte_d;
  logic             bv_q, bv_d;   // byte_valid
  logic             bf_q, bf_d;   // byte_ferr

  always_comb begin
    rx_st_d = rx_st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    byte_d  = byte_q;
    bv_d    = 1'b0;
    bf_d    = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          rx_st_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            rx_st_d = RX_IDLE;              // false start
          end else begin
            rx_st_d = RX_DATA;
            cnt_d   = BIT_LOAD;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          sr_d  = {rxs_q, sr_q[7:1]};       // LSB first
          cnt_d = BIT_LOAD;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          // Back to IDLE at the stop-bit centre so a start bit can
          // follow immediately.
          rx_st_d = RX_IDLE;
          if (rxs_q) begin
            bv_d   = 1'b1;
            byte_d = sr_q;
          end else begin
            bf_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge c50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      byte_q  <= '0;
      bv_q    <= 1'b0;
      bf_q    <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      bf_q    <= bf_d;
    end
  end

  // ---------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {P_HUNT, P_GOT_CMD, P_GOT_DATA, P_CHECK} p_state_e;

  p_state_e         p_st_q, p_st_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       dat_q, dat_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       cap_q, cap_d;
  logic [1:0]       mode_q, mode_d;
  logic             strobe_q, strobe_d;
  logic             err_q, err_d;
  logic [7:0]       csum;

  assign csum = cmd_q + dat_q;

  always_comb begin
    p_st_d   = p_st_q;
    cmd_d    = cmd_q;
    dat_d    = dat_q;
    cap_d    = cap_q;
    mode_d   = mode_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;

    // Inter-byte timer: idle in HUNT, cleared by every good byte,
    // saturates at the limit until the abort below takes effect.
    if (p_st_q == P_HUNT || bv_q)  tmr_d = '0;
    else if (tmr_q == TMO_LAST)    tmr_d = tmr_q;
    else                           tmr_d = tmr_q + 1'b1;

    unique case (p_st_q)
      P_HUNT: begin
        if (bv_q && byte_q == SYNC_BYTE) p_st_d = P_GOT_CMD;
      end
      P_GOT_CMD: begin
        if (bv_q) begin
          cmd_d  = byte_q;
          p_st_d = P_GOT_DATA;
        end
      end
      P_GOT_DATA: begin
        if (bv_q) begin
          dat_d  = byte_q;
          p_st_d = P_CHECK;
        end
      end
      P_CHECK: begin
        if (bv_q) begin
          p_st_d = P_HUNT;
          if (csum == byte_q && cmd_q == 8'h01 &&
              dat_q >= CAP_LO && dat_q <= CAP_HI) begin
            cap_d    = dat_q;
            strobe_d = 1'b1;
          end else if (csum == byte_q && cmd_q == 8'h02 && dat_q <= 8'd3) begin
            mode_d   = dat_q[1:0];
            strobe_d = 1'b1;
          end else begin
            err_d    = 1'b1;
          end
        end
      end
      default: p_st_d = P_HUNT;
    endcase

    // Aborts; bv_q and bf_q are mutually exclusive, and a good byte
    // arriving on the timeout cycle keeps the frame alive.
    if (p_st_q != P_HUNT && !bv_q && (bf_q || tmr_q == TMO_LAST)) begin
      p_st_d = P_HUNT;
      err_d  = 1'b1;
      tmr_d  = '0;
    end
  end

  always_ff @(posedge c50m or negedge rst_n) begin
    if (!rst_n) begin
      p_st_q   <= P_HUNT;
      cmd_q    <= '0;
      dat_q    <= '0;
      tmr_q    <= '0;
      cap_q    <= CAP_RST;
      mode_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      p_st_q   <= p_st_d;
      cmd_q    <= cmd_d;
      dat_q    <= dat_d;
      tmr_q    <= tmr_d;
      cap_q    <= cap_d;
      mode_q   <= mode_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign heart_cap   = cap_q;
  assign assist_mode = mode_q;
  assign cmd_strobe  = strobe_q;
  assign frame_err   = err_q;
  assign rx_busy     = (p_st_q != P_HUNT);

endmodule

// File: tb/tb_cell_command_rx.sv
module tb_cell_command_rx;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] heart_cap;
  logic [1:0] assist_mode;
  logic       cmd_strobe;
  logic       frame_err;
  logic       rx_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobe = 0;
  int n_err    = 0;
  int n_both   = 0;

  cell_command_rx #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (20 * CPB),
    .CAP_DEFAULT  (200),
    .CAP_MIN      (60),
    .CAP_MAX      (220)
  ) dut (
    .c50m        (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .heart_cap   (heart_cap),
    .assist_mode (assist_mode),
    .cmd_strobe  (cmd_strobe),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_strobe)              n_strobe++;
      if (frame_err)               n_err++;
      if (cmd_strobe && frame_err) n_both++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Sends a frame back to back, settles, checks pulse deltas.
  task automatic frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input int exp_strobe, input int exp_err);
    int s0, e0;
    s0 = n_strobe;
    e0 = n_err;
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    repeat (20) @(negedge clk);
    check({tag, "_strobe"}, n_strobe - s0, exp_strobe);
    check({tag, "_err"},    n_err - e0,    exp_err);
    check({tag, "_busy"},   int'(rx_busy), 0);
  endtask

  initial begin
    int s0, e0, waited;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_cap",    int'(heart_cap),   200);
    check("rst_mode",   int'(assist_mode), 0);
    check("rst_strobe", int'(cmd_strobe),  0);
    check("rst_err",    int'(frame_err),   0);
    check("rst_busy",   int'(rx_busy),     0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: cap 150
    frame("t1", 8'hA5, 8'h01, 8'h96, 8'h97, 1, 0);
    check("t1_cap", int'(heart_cap), 150);

    // 2: bad checksum, then assist 3
    frame("t2a", 8'hA5, 8'h01, 8'h96, 8'h00, 0, 1);
    check("t2a_cap", int'(heart_cap), 150);
    frame("t2b", 8'hA5, 8'h02, 8'h03, 8'h05, 1, 0);
    check("t2b_mode", int'(assist_mode), 3);

    // 3: range limits
    frame("t3a", 8'hA5, 8'h01, 8'h32, 8'h33, 0, 1);
    frame("t3b", 8'hA5, 8'h01, 8'hDD, 8'hDE, 0, 1);
    check("t3b_cap", int'(heart_cap), 150);
    frame("t3c", 8'hA5, 8'h01, 8'hDC, 8'hDD, 1, 0);
    check("t3c_cap", int'(heart_cap), 220);
    frame("t3d", 8'hA5, 8'h01, 8'h3C, 8'h3D, 1, 0);
    check("t3d_cap", int'(heart_cap), 60);
    frame("t3e", 8'hA5, 8'h02, 8'h04, 8'h06, 0, 1);
    check("t3e_mode", int'(assist_mode), 3);
    frame("t3f", 8'hA5, 8'h03, 8'h01, 8'h04, 0, 1);

    // 4: garbage dropped silently, then assist 1; false start
    e0 = n_err;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h13, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_garbage_err",  n_err - e0, 0);
    check("t4_garbage_busy", int'(rx_busy), 0);
    frame("t4", 8'hA5, 8'h02, 8'h01, 8'h03, 1, 0);
    check("t4_mode", int'(assist_mode), 1);
    s0 = n_strobe;
    e0 = n_err;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_false_pulses", (n_strobe - s0) + (n_err - e0), 0);
    check("t4_false_busy",   int'(rx_busy), 0);
    frame("t4b", 8'hA5, 8'h02, 8'h02, 8'h04, 1, 0);
    check("t4b_mode", int'(assist_mode), 2);

    // 5a: framing error on CMD byte
    e0 = n_err;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b0);
    repeat (20) @(negedge clk);
    check("t5a_err",  n_err - e0, 1);
    check("t5a_busy", int'(rx_busy), 0);

    // 5b: inter-byte timeout
    e0 = n_err;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    check("t5b_busy_mid", int'(rx_busy), 1);
    waited = 0;
    while (n_err == e0 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check("t5b_err",   n_err - e0, 1);
    check("t5b_late",  int'(waited >= 300), 1);
    check("t5b_busy",  int'(rx_busy), 0);
    check("t5b_cap",   int'(heart_cap), 60);

    // 6: reset mid DATA byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_cap",  int'(heart_cap),   200);
    check("t6_rst_mode", int'(assist_mode), 0);
    check("t6_rst_busy", int'(rx_busy),     0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    frame("t6", 8'hA5, 8'h01, 8'h64, 8'h65, 1, 0);
    check("t6_cap", int'(heart_cap), 100);

    check("never_both", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
